// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_pkg
//  Purpose  : Shared types and constants for the load/store front end:
//             access-size encodings, FSM state type, address-width default
//             and the alignment check.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // A halfword must sit on an even byte, a word on a 4-byte boundary; the
  // reserved size code is never a legal access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic w_bad;
    case (size)
      SZ_BYTE: w_bad = 1'b0;
      SZ_HALF: w_bad = offset[0];
      SZ_WORD: w_bad = (offset != 2'b00);
      default: w_bad = 1'b1;
    endcase
    return w_bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Little-endian lane steering between 32-bit RAM words and
//             byte/halfword/word CPU data. Load side extracts and extends a
//             lane; store side merges new data into the previously read word.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_store_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned_load,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_value,
  output logic [31:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    w_byte = i_load_word[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_load_word[31:16] : i_load_word[15:0];
    case (i_size)
      SZ_BYTE: o_load_value = {{24{~i_unsigned_load & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_value = {{16{~i_unsigned_load & w_half[15]}}, w_half};
      default: o_load_value = i_load_word;
    endcase
  end

  // Store path: replace only the addressed lane(s); a word store replaces all.
  always_comb begin
    o_merged_word = i_store_word;
    case (i_size)
      SZ_BYTE: o_merged_word[{i_offset, 3'b000} +: 8] = i_store_data[7:0];
      SZ_HALF: begin
        if (i_offset[1]) o_merged_word[31:16] = i_store_data[15:0];
        else             o_merged_word[15:0]  = i_store_data[15:0];
      end
      default: o_merged_word = i_store_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Byte-addressed load/store front end for a word-wide RAM.
//             Sub-word stores are done as read-modify-write; misaligned or
//             illegal requests are rejected without touching the RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
)(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Write,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] ByteAddr,
  input  logic [31:0]       StoreData,
  output logic              Busy,
  output logic              Done,
  output logic              Misaligned,
  output logic [31:0]       LoadData,
  output logic [ADDR_W-3:0] RamAddress,
  output logic              RamMemWrite,
  output logic [31:0]       RamWriteData,
  input  logic [31:0]       RamReadData
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_offset;
  logic [31:0]       r_store_data;
  logic [31:0]       r_word;
  logic [31:0]       r_load_data;
  logic [ADDR_W-3:0] r_ram_addr;
  logic              r_mem_write;
  logic              w_accept;
  logic              w_req_misaligned;
  logic              w_busy;
  logic              w_done;
  logic              w_misaligned;
  logic [31:0]       w_load_value;
  logic [31:0]       w_merged_word;

  assign w_req_misaligned = is_misaligned(Size, ByteAddr[1:0]);

  // DONE and ERR take a new request exactly like IDLE, so a CPU holding Req
  // gets back-to-back accesses with no idle cycle in between.
  assign w_accept = Req && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));

  // Next-state decode and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_busy       = (r_state != IDLE);
    w_done       = (r_state == DONE) || (r_state == ERR);
    w_misaligned = (r_state == ERR);
    case (r_state)
      IDLE, DONE, ERR: begin
        if (!Req)                               w_next_state = IDLE;
        else if (w_req_misaligned)              w_next_state = ERR;
        else if (Write && (Size == SZ_WORD))    w_next_state = WRITE;
        else                                    w_next_state = READ;
      end
      READ:    w_next_state = r_write ? WRITE : DONE;
      WRITE:   w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Request latch, loaded on every accepted request.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_write      <= 1'b0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_offset     <= 2'b00;
      r_store_data <= '0;
    end else if (w_accept) begin
      r_write      <= Write;
      r_size       <= Size;
      r_unsigned   <= Unsigned;
      r_offset     <= ByteAddr[1:0];
      r_store_data <= StoreData;
    end
  end

  // RAM address holds between accesses; rejected requests leave it alone.
  // The write strobe is a flop set only for the cycle spent in WRITE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ram_addr  <= '0;
      r_mem_write <= 1'b0;
    end else begin
      r_mem_write <= (w_next_state == WRITE);
      if (w_accept && !w_req_misaligned) r_ram_addr <= ByteAddr[ADDR_W-1:2];
    end
  end

  // Word register and load result, both captured at the close of READ.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_word      <= '0;
      r_load_data <= '0;
    end else if (r_state == READ) begin
      r_word <= RamReadData;
      if (!r_write) r_load_data <= w_load_value;
    end
  end

  mem_lane_align u_align (
    .i_load_word     (RamReadData),
    .i_store_word    (r_word),
    .i_offset        (r_offset),
    .i_size          (r_size),
    .i_unsigned_load (r_unsigned),
    .i_store_data    (r_store_data),
    .o_load_value    (w_load_value),
    .o_merged_word   (w_merged_word)
  );

  assign Busy         = w_busy;
  assign Done         = w_done;
  assign Misaligned   = w_misaligned;
  assign LoadData     = r_load_data;
  assign RamAddress   = r_ram_addr;
  assign RamMemWrite  = r_mem_write;
  assign RamWriteData = (r_state == WRITE) ? w_merged_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit with an attached word
//             RAM and a byte-array reference model of memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        Clock;
  logic        Reset;
  logic        Req;
  logic        Write;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [15:0] ByteAddr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic        Misaligned;
  logic [31:0] LoadData;
  logic [13:0] RamAddress;
  logic        RamMemWrite;
  logic [31:0] RamWriteData;
  logic [31:0] RamReadData;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ram [0:16383];
  logic [7:0]  mbytes [0:65535];
  logic [31:0] exp_load;

  mem_access_unit #(.ADDR_W(16)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Req          (Req),
    .Write        (Write),
    .Size         (Size),
    .Unsigned     (Unsigned),
    .ByteAddr     (ByteAddr),
    .StoreData    (StoreData),
    .Busy         (Busy),
    .Done         (Done),
    .Misaligned   (Misaligned),
    .LoadData     (LoadData),
    .RamAddress   (RamAddress),
    .RamMemWrite  (RamMemWrite),
    .RamWriteData (RamWriteData),
    .RamReadData  (RamReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Word RAM: combinational read, write on the rising edge.
  assign RamReadData = ram[RamAddress];
  always @(posedge Clock) begin
    if (RamMemWrite) ram[RamAddress] <= RamWriteData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bad(input logic [1:0] sz, input logic [15:0] addr);
    int n;
    if (sz == 2'd3) return 1'b1;
    n = 1 << sz;
    return (int'(addr) % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [15:0] addr);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mbytes[addr + 16'(i)]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] model_word(input logic [13:0] w);
    return {mbytes[{w, 2'd3}], mbytes[{w, 2'd2}], mbytes[{w, 2'd1}], mbytes[{w, 2'd0}]};
  endfunction

  // One complete request: present for one accepting edge, then watch the
  // DUT for Done within a bounded number of cycles.
  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [15:0] addr, input logic [31:0] data, input string tag);
    bit          bad;
    bit          seen;
    int          lat;
    int          wcnt;
    int          exp_lat;
    logic        mis;
    logic [13:0] waddr;
    logic [31:0] v;
    bad  = model_bad(sz, addr);
    seen = 1'b0;
    lat  = 0;
    wcnt = 0;
    mis  = 1'b0;
    waddr = 14'h0;
    @(negedge Clock);
    Req = 1'b1; Write = wr; Size = sz; Unsigned = uns; ByteAddr = addr; StoreData = data;
    @(posedge Clock);
    #1;
    Req = 1'b0;
    ByteAddr  = 16'($urandom);
    StoreData = $urandom;
    for (int c = 1; c <= 8 && !seen; c++) begin
      if (c > 1) begin
        @(posedge Clock);
        #1;
      end
      if (RamMemWrite) begin
        wcnt++;
        waddr = RamAddress;
      end
      if (Done) begin
        seen = 1'b1;
        lat  = c;
        mis  = Misaligned;
      end
    end
    exp_lat = bad ? 1 : (!wr ? 2 : (sz == 2'd2 ? 2 : 3));
    if (!bad) begin
      if (wr) begin
        v = data;
        for (int i = 0; i < (1 << sz); i++) mbytes[addr + 16'(i)] = v[8*i +: 8];
      end else begin
        exp_load = model_load(sz, uns, addr);
      end
    end
    check({tag, ".latency"},    32'(lat),  32'(exp_lat));
    check({tag, ".misaligned"}, 32'(mis),  32'(bad));
    check({tag, ".writes"},     32'(wcnt), (wr && !bad) ? 32'd1 : 32'd0);
    check({tag, ".loaddata"},   LoadData,  exp_load);
    check({tag, ".ramword"},    ram[addr[15:2]], model_word(addr[15:2]));
    if (wcnt > 0) check({tag, ".waddr"}, 32'(waddr), 32'(addr[15:2]));
  endtask

  initial begin
    logic [31:0] v;
    Reset = 1'b1; Req = 1'b0; Write = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    ByteAddr = 16'h0; StoreData = 32'h0;
    exp_load = 32'h0;
    for (int i = 0; i < 65536; i++) mbytes[i] = 8'h00;
    for (int i = 0; i < 16384; i++) begin
      v = (i < 32) ? $urandom : 32'h0;
      ram[i] <= v;
      for (int k = 0; k < 4; k++) mbytes[4*i + k] = v[8*k +: 8];
    end
    #2 Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset.busy",       32'(Busy),         32'h0);
    check("reset.done",       32'(Done),         32'h0);
    check("reset.misaligned", 32'(Misaligned),   32'h0);
    check("reset.memwrite",   32'(RamMemWrite),  32'h0);
    check("reset.ramaddr",    32'(RamAddress),   32'h0);
    check("reset.wdata",      RamWriteData,      32'h0);
    check("reset.loaddata",   LoadData,          32'h0);
    @(negedge Clock);
    Reset = 1'b1;

    // Word store and word load-back.
    access(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, "wst");
    access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        "wld");
    check("wld.value", LoadData, 32'hDEADBEEF);

    // Byte read-modify-write; upper StoreData bits must be ignored.
    access(1'b1, 2'd2, 1'b0, 16'h0010, 32'h11223344, "wst2");
    access(1'b1, 2'd0, 1'b0, 16'h0012, 32'h123456AA, "bst");
    check("bst.word", ram[4], 32'h11AA3344);

    // Extension of loaded lanes.
    access(1'b0, 2'd0, 1'b0, 16'h0012, 32'h0, "lb");
    check("lb.value", LoadData, 32'hFFFFFFAA);
    access(1'b0, 2'd0, 1'b1, 16'h0012, 32'h0, "lbu");
    check("lbu.value", LoadData, 32'h000000AA);
    access(1'b0, 2'd1, 1'b0, 16'h0012, 32'h0, "lh");
    check("lh.value", LoadData, 32'h000011AA);

    // Rejected requests.
    access(1'b0, 2'd1, 1'b0, 16'h0013, 32'h0,        "mis_lh");
    access(1'b1, 2'd2, 1'b0, 16'h0012, 32'hCAFEF00D, "mis_sw");
    access(1'b0, 2'd3, 1'b0, 16'h0010, 32'h0,        "mis_sz");

    // Handshake: Req held high across two loads.
    access(1'b1, 2'd2, 1'b0, 16'h0014, 32'h5A5AC3C3, "hs_pre");
    @(negedge Clock);
    Req = 1'b1; Write = 1'b0; Size = 2'd2; Unsigned = 1'b0; ByteAddr = 16'h0010;
    @(posedge Clock);
    #1;
    check("hs.c1_busy", 32'(Busy), 32'h1);
    check("hs.c1_done", 32'(Done), 32'h0);
    @(posedge Clock);
    #1;
    exp_load = model_load(2'd2, 1'b0, 16'h0010);
    check("hs.c2_done", 32'(Done), 32'h1);
    check("hs.c2_load", LoadData, exp_load);
    @(negedge Clock);
    ByteAddr = 16'h0014;
    @(posedge Clock);
    #1;
    Req = 1'b0;
    check("hs.c3_busy", 32'(Busy), 32'h1);
    check("hs.c3_done", 32'(Done), 32'h0);
    @(posedge Clock);
    #1;
    exp_load = model_load(2'd2, 1'b0, 16'h0014);
    check("hs.c4_done", 32'(Done), 32'h1);
    check("hs.c4_load", LoadData, exp_load);
    @(posedge Clock);
    #1;
    check("hs.c5_busy", 32'(Busy), 32'h0);

    // Reset in the WRITE cycle of a byte store.
    @(negedge Clock);
    Req = 1'b1; Write = 1'b1; Size = 2'd0; Unsigned = 1'b0; ByteAddr = 16'h0011; StoreData = 32'h77;
    @(posedge Clock);
    #1;
    Req = 1'b0;
    check("rst.c1_busy", 32'(Busy), 32'h1);
    @(posedge Clock);
    #1;
    check("rst.c2_memwrite", 32'(RamMemWrite), 32'h1);
    #3 Reset = 1'b0;
    #1;
    exp_load = 32'h0;
    check("rst.memwrite", 32'(RamMemWrite), 32'h0);
    check("rst.busy",     32'(Busy),        32'h0);
    check("rst.done",     32'(Done),        32'h0);
    check("rst.ramaddr",  32'(RamAddress),  32'h0);
    check("rst.wdata",    RamWriteData,     32'h0);
    check("rst.loaddata", LoadData,         32'h0);
    repeat (2) @(posedge Clock);
    #1;
    check("rst.nodone", 32'(Done), 32'h0);
    check("rst.ramword", ram[4], model_word(14'd4));
    @(negedge Clock);
    Reset = 1'b1;
    access(1'b0, 2'd0, 1'b1, 16'h0011, 32'h0, "post_rst");

    // Randomised traffic against the byte model.
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      logic [1:0]  s;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~16'((1 << s) - 1);
      access(1'($urandom), s, 1'($urandom), a, $urandom, "rnd");
    end

    repeat (2) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
